// File: rtl/input_port_buffer_bank.sv
// Bank of 2-entry input FIFOs with a producer valid/ready handshake. Every port's
// head word is exposed on a flat bus, and a raw read address pops the port it decodes to.
module input_port_buffer_bank #(
   parameter int WORD_WIDTH      = 36,
   parameter int ADDR_WIDTH      = 10,
   parameter int PORT_COUNT      = 4,
   parameter int PORT_BASE_ADDR  = 0,
   parameter int PORT_ADDR_WIDTH = 2
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data,
   input  logic [PORT_COUNT-1:0]            in_valid,
   output logic [PORT_COUNT-1:0]            in_ready,
   input  logic [ADDR_WIDTH-1:0]            read_addr,
   input  logic                             read_enable,
   output logic [PORT_COUNT*WORD_WIDTH-1:0] port_data,
   output logic                             read_hit,
   output logic                             read_empty,
   output logic [2*PORT_COUNT-1:0]          port_count
);

   // One extra bit so that BASE+COUNT cannot wrap at the top of the address space.
   localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH+1)'(PORT_BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] RANGE_HI = (ADDR_WIDTH+1)'(PORT_BASE_ADDR + PORT_COUNT);

   logic [WORD_WIDTH-1:0]      head_q [PORT_COUNT];
   logic [WORD_WIDTH-1:0]      head_d [PORT_COUNT];
   logic [WORD_WIDTH-1:0]      tail_q [PORT_COUNT];
   logic [WORD_WIDTH-1:0]      tail_d [PORT_COUNT];
   logic [1:0]                 occ_q  [PORT_COUNT];
   logic [1:0]                 occ_d  [PORT_COUNT];
   logic [PORT_COUNT-1:0]      ready_q;
   logic [PORT_COUNT-1:0]      ready_d;
   logic [PORT_ADDR_WIDTH-1:0] port_idx;
   logic [PORT_COUNT-1:0]      sel;
   logic [PORT_COUNT-1:0]      push;
   logic [PORT_COUNT-1:0]      pop;

   // Port select only qualifies when the range check passes, so the truncated index is safe.
   always_comb begin
      read_hit   = ({1'b0, read_addr} >= RANGE_LO) && ({1'b0, read_addr} < RANGE_HI);
      port_idx   = PORT_ADDR_WIDTH'(read_addr - ADDR_WIDTH'(PORT_BASE_ADDR));
      read_empty = 1'b0;
      sel        = '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         sel[i] = read_hit && (port_idx == PORT_ADDR_WIDTH'(i));
         if (sel[i] && (occ_q[i] == 2'd0)) begin
            read_empty = 1'b1;
         end
      end
   end

   always_comb begin
      push    = '0;
      pop     = '0;
      ready_d = '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         push[i]   = in_valid[i] && ready_q[i];
         pop[i]    = read_enable && sel[i] && (occ_q[i] != 2'd0);
         head_d[i] = head_q[i];
         tail_d[i] = tail_q[i];
         occ_d[i]  = occ_q[i];
         if (push[i] && pop[i]) begin
            // Only reachable at occupancy 1: the incoming word replaces the head in place.
            head_d[i] = in_data[i*WORD_WIDTH +: WORD_WIDTH];
         end else if (push[i]) begin
            if (occ_q[i] == 2'd0) begin
               head_d[i] = in_data[i*WORD_WIDTH +: WORD_WIDTH];
            end else begin
               tail_d[i] = in_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
            occ_d[i] = occ_q[i] + 2'd1;
         end else if (pop[i]) begin
            if (occ_q[i] == 2'd2) begin
               head_d[i] = tail_q[i];
            end
            occ_d[i] = occ_q[i] - 2'd1;
         end
         ready_d[i] = (occ_d[i] != 2'd2);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_q <= '0;
         for (int i = 0; i < PORT_COUNT; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            occ_q[i]  <= 2'd0;
         end
      end else begin
         ready_q <= ready_d;
         for (int i = 0; i < PORT_COUNT; i++) begin
            head_q[i] <= head_d[i];
            tail_q[i] <= tail_d[i];
            occ_q[i]  <= occ_d[i];
         end
      end
   end

   always_comb begin
      in_ready = ready_q;
      for (int i = 0; i < PORT_COUNT; i++) begin
         port_data[i*WORD_WIDTH +: WORD_WIDTH] = head_q[i];
         port_count[2*i +: 2]                  = occ_q[i];
      end
   end

endmodule

// File: tb/tb_input_port_buffer_bank.sv
// Bench for input_port_buffer_bank: directed scenarios plus a random phase, checked
// against a queue-based model of the port bank.
module tb_input_port_buffer_bank;

   localparam int WW   = 36;
   localparam int AW   = 10;
   localparam int PC   = 4;
   localparam int BASE = 5;
   localparam int PAW  = 2;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [PC*WW-1:0] in_data;
   logic [PC-1:0]    in_valid;
   logic [PC-1:0]    in_ready;
   logic [AW-1:0]    read_addr;
   logic             read_enable;
   logic [PC*WW-1:0] port_data;
   logic             read_hit;
   logic             read_empty;
   logic [2*PC-1:0]  port_count;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one queue per port, plus the word last popped from each port.
   logic [WW-1:0] mq [PC][$];
   logic [WW-1:0] mlast [PC];
   logic [PC-1:0] mrdy;

   input_port_buffer_bank #(
      .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .PORT_COUNT(PC),
      .PORT_BASE_ADDR(BASE), .PORT_ADDR_WIDTH(PAW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .read_addr(read_addr), .read_enable(read_enable),
      .port_data(port_data), .read_hit(read_hit), .read_empty(read_empty),
      .port_count(port_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_hit(input int a);
      return (a >= BASE) && (a < BASE + PC);
   endfunction

   task automatic m_reset();
      for (int p = 0; p < PC; p++) begin
         mq[p].delete();
         mlast[p] = '0;
      end
      mrdy = '0;
   endtask

   task automatic m_edge();
      int a;
      a = int'(read_addr);
      for (int p = 0; p < PC; p++) begin
         if (read_enable && m_hit(a) && (a - BASE == p) && mq[p].size() > 0)
            mlast[p] = mq[p].pop_front();
         if (in_valid[p] && mrdy[p])
            mq[p].push_back(in_data[p*WW +: WW]);
      end
      for (int p = 0; p < PC; p++) mrdy[p] = (mq[p].size() < 2);
   endtask

   task automatic check_state(input string tag);
      logic [PC*WW-1:0] ed;
      logic [2*PC-1:0]  ec;
      for (int p = 0; p < PC; p++) begin
         ed[p*WW +: WW] = (mq[p].size() > 0) ? mq[p][0] : mlast[p];
         ec[2*p +: 2]   = 2'(mq[p].size());
      end
      chk({tag, ".in_ready"}, in_ready, mrdy);
      chk({tag, ".port_count"}, port_count, ec);
      chk({tag, ".port_data"}, port_data, ed);
   endtask

   task automatic step(input string tag, input logic [PC-1:0] v, input logic [PC*WW-1:0] d,
                       input logic ren, input logic [AW-1:0] a);
      logic eh, ee;
      int   ai;
      in_valid    = v;
      in_data     = d;
      read_enable = ren;
      read_addr   = a;
      #1;
      ai = int'(a);
      eh = m_hit(ai);
      ee = eh && (mq[ai - BASE].size() == 0);
      chk({tag, ".read_hit"}, read_hit, eh);
      chk({tag, ".read_empty"}, read_empty, ee);
      @(posedge clock);
      m_edge();
      #1;
      check_state(tag);
   endtask

   function automatic logic [PC*WW-1:0] pd(input int p, input logic [WW-1:0] w);
      logic [PC*WW-1:0] d;
      d = '0;
      d[p*WW +: WW] = w;
      return d;
   endfunction

   function automatic logic [PC*WW-1:0] rnd_data();
      logic [PC*WW-1:0] d;
      for (int p = 0; p < PC; p++) d[p*WW +: WW] = WW'({$urandom, $urandom});
      return d;
   endfunction

   initial begin
      reset_n     = 1'b0;
      in_valid    = '0;
      in_data     = '0;
      read_enable = 1'b0;
      read_addr   = '0;
      m_reset();
      #12;
      check_state("reset");
      chk("reset.in_ready_const", in_ready, 4'b0000);
      #10 reset_n = 1'b1;
      step("release", '0, '0, 1'b0, 10'd0);
      chk("release.in_ready_const", in_ready, 4'b1111);

      // Fill and drain port 2 (address 7).
      step("push_a1", 4'b0100, pd(2, 36'hA1), 1'b0, 10'd0);
      step("push_a2", 4'b0100, pd(2, 36'hA2), 1'b0, 10'd0);
      chk("full.ready2", in_ready[2], 1'b0);
      chk("full.count2", port_count[5:4], 2'd2);
      chk("full.data2", port_data[2*WW +: WW], 36'hA1);
      step("pop1", '0, '0, 1'b1, 10'd7);
      chk("pop1.data2", port_data[2*WW +: WW], 36'hA2);
      chk("pop1.count2", port_count[5:4], 2'd1);
      step("pop2", '0, '0, 1'b1, 10'd7);
      chk("pop2.data2", port_data[2*WW +: WW], 36'hA2);
      chk("pop2.count2", port_count[5:4], 2'd0);
      chk("pop2.ready2", in_ready[2], 1'b1);

      // Empty read on port 1, then out-of-range addresses around a loaded port 3.
      step("empty_rd", '0, '0, 1'b1, 10'd6);
      step("push_p3", 4'b1000, pd(3, 36'h33), 1'b0, 10'd0);
      step("below", '0, '0, 1'b1, 10'd4);
      step("above", '0, '0, 1'b1, 10'd9);
      chk("above.count3", port_count[7:6], 2'd1);
      step("hit_p3", '0, '0, 1'b1, 10'd8);
      chk("hit_p3.count3", port_count[7:6], 2'd0);

      // Concurrent push and pop on port 0 at occupancy 1.
      step("push_11", 4'b0001, pd(0, 36'h11), 1'b0, 10'd0);
      step("pushpop", 4'b0001, pd(0, 36'h22), 1'b1, 10'd5);
      chk("pushpop.data0", port_data[WW-1:0], 36'h22);
      chk("pushpop.count0", port_count[1:0], 2'd1);
      chk("pushpop.ready0", in_ready[0], 1'b1);

      // Load every port to occupancy 2, then reset between edges.
      step("fill_a", 4'hF, rnd_data(), 1'b0, 10'd0);
      step("fill_b", 4'hF, rnd_data(), 1'b0, 10'd0);
      chk("fill.count", port_count, 8'hAA);
      #2 reset_n = 1'b0;
      #1;
      m_reset();
      check_state("midrst");
      #3 reset_n = 1'b1;
      step("post_rst", '0, '0, 1'b0, 10'd0);
      step("post_rd", '0, '0, 1'b1, 10'd5);

      // Random traffic across and around the port range.
      for (int n = 0; n < 400; n++) begin
         step("rand", PC'($urandom), rnd_data(), ($urandom_range(0, 3) != 0),
              AW'($urandom_range(3, 10)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
